serial_link_tx: RTL and testbench

- Transmit end of the 1-bit inter-node serial link; the receive end is the existing per-direction link receiver.
- Takes parallel flits from a router output port via a valid/busy handshake and frames each one onto tx_data.
- Holds off new frames while the downstream receiver asserts its busy line.
- One instance per mesh direction (N/E/S/W) inside the node, clocked by the node clk.

---
 rtl/serial_link_tx.sv | 133 +++++++++++++
 tb/tb_serial_link_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_tx.sv
// Transmit end of the 1-bit inter-node serial link: accepts flits through a valid/busy handshake and
// frames them as START, LSB-first data, even parity and a gap, gated by the receiver's busy line.
module serial_link_tx #(
  parameter int unsigned FLIT_W = 16,
  parameter int unsigned CNT_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] item_in,
  input  logic              valid,
  output logic              busy,
  input  logic              rx_busy_remote,
  output logic              tx_data,
  output logic              tx_active,
  output logic [CNT_W-1:0]  flit_counter
);

  localparam int unsigned BitCntW = $clog2(FLIT_W + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(FLIT_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StGap
  } state_e;

  state_e              state_q, state_d;
  logic [FLIT_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [FLIT_W-1:0]   shift_q, shift_d;
  logic                parity_q, parity_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic                tx_data_q, tx_data_d;
  logic                tx_active_q, tx_active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sync1_q, busy_s_q;
  logic                load_ok;

  // Downstream busy is treated as asserted until the synchronizer has seen it low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      tx_data_q   <= 1'b0;
      tx_active_q <= 1'b0;
      cnt_q       <= '0;
      sync1_q     <= 1'b1;
      busy_s_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_active_q <= tx_active_d;
      cnt_q       <= cnt_d;
      sync1_q     <= rx_busy_remote;
      busy_s_q    <= sync1_q;
    end
  end

  assign load_ok = hold_full_q && !busy_s_q;

  // tx_data_d/tx_active_d describe the state being entered, so the line is fully registered.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_cnt_d   = bit_cnt_q;
    cnt_d       = cnt_q;
    tx_data_d   = 1'b0;
    tx_active_d = 1'b0;

    if (valid && !hold_full_q) begin
      hold_d      = item_in;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle, StGap: begin
        if (load_ok) begin
          state_d     = StStart;
          shift_d     = hold_q;
          parity_d    = ^hold_q;
          hold_full_d = 1'b0;
          tx_data_d   = 1'b1;
          tx_active_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        state_d     = StData;
        bit_cnt_d   = '0;
        tx_data_d   = shift_q[0];
        shift_d     = shift_q >> 1;
        tx_active_d = 1'b1;
      end
      StData: begin
        tx_active_d = 1'b1;
        if (bit_cnt_q == LastBit) begin
          state_d   = StParity;
          tx_data_d = parity_q;
        end else begin
          tx_data_d = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end
      StParity: begin
        state_d = StGap;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy         = hold_full_q;
  assign tx_data      = tx_data_q;
  assign tx_active    = tx_active_q;
  assign flit_counter = cnt_q;

endmodule

// File: tb/tb_serial_link_tx.sv
// Directed bench for serial_link_tx: framing, back-to-back throughput, remote busy, async reset and
// counter wrap (second instance with a 2-bit counter sharing the same stimulus).
module tb_serial_link_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] item_in;
  logic        valid;
  logic        rx_busy_remote;
  logic        busy, tx_data, tx_active;
  logic [19:0] flit_counter;
  logic        busy2, tx_data2, tx_active2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  logic [15:0] vec;
  logic [15:0] t6_items [5];
  logic        t6_par   [5];
  logic [1:0]  t6_cnt2  [5];
  int          n;

  always #5 clk = ~clk;

  serial_link_tx #(.FLIT_W(16), .CNT_W(20)) dut (
    .clk            (clk),
    .reset          (reset),
    .item_in        (item_in),
    .valid          (valid),
    .busy           (busy),
    .rx_busy_remote (rx_busy_remote),
    .tx_data        (tx_data),
    .tx_active      (tx_active),
    .flit_counter   (flit_counter)
  );

  serial_link_tx #(.FLIT_W(16), .CNT_W(2)) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .item_in        (item_in),
    .valid          (valid),
    .busy           (busy2),
    .rx_busy_remote (rx_busy_remote),
    .tx_data        (tx_data2),
    .tx_active      (tx_active2),
    .flit_counter   (cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that showed START; walks data, parity and gap.
  task automatic check_frame(input string tag, input logic [15:0] d, input logic par,
                             input int rb_at);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("%s_bit%0d", tag, i), {31'd0, tx_data}, {31'd0, d[i]});
      if (i == rb_at) rx_busy_remote = 1'b1;
    end
    step();
    chk({tag, "_parity"}, {31'd0, tx_data}, {31'd0, par});
    chk({tag, "_parity_active"}, {31'd0, tx_active}, 32'd1);
    step();
    chk({tag, "_gap"}, {31'd0, tx_data}, 32'd0);
    chk({tag, "_gap_active"}, {31'd0, tx_active}, 32'd0);
  endtask

  initial begin
    t6_items[0] = 16'h0003; t6_par[0] = 1'b0; t6_cnt2[0] = 2'd1;
    t6_items[1] = 16'h0010; t6_par[1] = 1'b1; t6_cnt2[1] = 2'd2;
    t6_items[2] = 16'h0101; t6_par[2] = 1'b0; t6_cnt2[2] = 2'd3;
    t6_items[3] = 16'h0700; t6_par[3] = 1'b1; t6_cnt2[3] = 2'd0;
    t6_items[4] = 16'h8000; t6_par[4] = 1'b1; t6_cnt2[4] = 2'd1;

    reset = 1'b1; valid = 1'b0; item_in = '0; rx_busy_remote = 1'b0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx", {31'd0, tx_data}, 32'd0);
    chk("rst_active", {31'd0, tx_active}, 32'd0);
    chk("rst_cnt", {12'd0, flit_counter}, 32'd0);
    reset = 1'b0;
    step(); step(); step();

    // Single flit
    item_in = 16'h00A5; valid = 1'b1;
    step();
    chk("t1_busy_after_accept", {31'd0, busy}, 32'd1);
    chk("t1_tx_idle", {31'd0, tx_data}, 32'd0);
    valid = 1'b0;
    step();
    chk("t1_start", {31'd0, tx_data}, 32'd1);
    chk("t1_start_active", {31'd0, tx_active}, 32'd1);
    chk("t1_busy_released", {31'd0, busy}, 32'd0);
    check_frame("t1", 16'h00A5, 1'b0, -1);
    chk("t1_cnt", {12'd0, flit_counter}, 32'd1);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);

    // Back-to-back
    item_in = 16'hFFFF; valid = 1'b1;
    step();
    chk("t2_busy_a", {31'd0, busy}, 32'd1);
    item_in = 16'h0001;
    step();
    chk("t2_start_a", {31'd0, tx_data}, 32'd1);
    chk("t2_busy_free", {31'd0, busy}, 32'd0);
    n = 0;
    step(); n++;
    chk("t2_busy_b", {31'd0, busy}, 32'd1);
    chk("t2_a_bit0", {31'd0, tx_data}, 32'd1);
    valid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step(); n++;
      chk($sformatf("t2_a_bit%0d", i), {31'd0, tx_data}, 32'd1);
    end
    step(); n++;
    chk("t2_a_parity", {31'd0, tx_data}, 32'd0);
    step(); n++;
    chk("t2_a_gap", {31'd0, tx_data}, 32'd0);
    chk("t2_busy_in_gap", {31'd0, busy}, 32'd1);
    step(); n++;
    chk("t2_start_b", {31'd0, tx_data}, 32'd1);
    chk("t2_busy_rel_on_load", {31'd0, busy}, 32'd0);
    chk("t2_period", n, 32'd19);
    check_frame("t2b", 16'h0001, 1'b1, -1);
    chk("t2_cnt", {12'd0, flit_counter}, 32'd3);

    // Remote busy holds off the frame
    rx_busy_remote = 1'b1;
    step(); step(); step();
    item_in = 16'h1234; valid = 1'b1;
    step();
    chk("t3_busy", {31'd0, busy}, 32'd1);
    valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t3_hold_tx%0d", i), {31'd0, tx_data}, 32'd0);
    end
    chk("t3_hold_busy", {31'd0, busy}, 32'd1);
    rx_busy_remote = 1'b0;
    step();
    chk("t3_e1", {31'd0, tx_data}, 32'd0);
    step();
    chk("t3_e2", {31'd0, tx_data}, 32'd0);
    step();
    chk("t3_e3_start", {31'd0, tx_data}, 32'd1);
    check_frame("t3", 16'h1234, 1'b1, -1);
    chk("t3_cnt", {12'd0, flit_counter}, 32'd4);

    // Remote busy asserted mid-frame
    item_in = 16'h00F0; valid = 1'b1;
    step();
    item_in = 16'h0007;
    step();
    chk("t4_start_a", {31'd0, tx_data}, 32'd1);
    check_frame("t4a", 16'h00F0, 1'b0, 5);
    valid = 1'b0;
    chk("t4_pending_busy", {31'd0, busy}, 32'd1);
    chk("t4_cnt", {12'd0, flit_counter}, 32'd5);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t4_held%0d", i), {31'd0, tx_data}, 32'd0);
    end
    rx_busy_remote = 1'b0;
    step(); step();
    chk("t4_e2", {31'd0, tx_data}, 32'd0);
    step();
    chk("t4_start_b", {31'd0, tx_data}, 32'd1);
    check_frame("t4b", 16'h0007, 1'b1, -1);

    // Asynchronous reset during data bit 8
    item_in = 16'h5A5A; valid = 1'b1;
    step();
    item_in = 16'h1111;
    step();
    chk("t5_start", {31'd0, tx_data}, 32'd1);
    vec = 16'h5A5A;
    for (int i = 0; i <= 8; i++) begin
      step();
      chk($sformatf("t5_bit%0d", i), {31'd0, tx_data}, {31'd0, vec[i]});
    end
    valid = 1'b0;
    chk("t5_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_rst_tx", {31'd0, tx_data}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_active", {31'd0, tx_active}, 32'd0);
    chk("t5_rst_cnt", {12'd0, flit_counter}, 32'd0);
    step();
    reset = 1'b0;
    item_in = 16'h8001; valid = 1'b1;
    step();
    chk("t5_accept", {31'd0, busy}, 32'd1);
    chk("t5_e1", {31'd0, tx_data}, 32'd0);
    valid = 1'b0;
    step();
    chk("t5_e2", {31'd0, tx_data}, 32'd0);
    step();
    chk("t5_e3_start", {31'd0, tx_data}, 32'd1);
    check_frame("t5", 16'h8001, 1'b0, -1);
    chk("t5_cnt", {12'd0, flit_counter}, 32'd1);

    // Counter wrap on the 2-bit instance
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(); step();
    for (int j = 0; j < 5; j++) begin
      item_in = t6_items[j]; valid = 1'b1;
      step();
      valid = 1'b0;
      step();
      chk($sformatf("t6_start%0d", j), {31'd0, tx_data}, 32'd1);
      check_frame($sformatf("t6_%0d", j), t6_items[j], t6_par[j], -1);
      chk($sformatf("t6_cnt2_%0d", j), {30'd0, cnt2}, {30'd0, t6_cnt2[j]});
      chk($sformatf("t6_cnt_%0d", j), {12'd0, flit_counter}, j + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
